// File: rtl/mio_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states, grant codes,
// and the width of the access-latency counter.
`timescale 1ns/1ps
package mio_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   localparam int CNT_W = 4;

   // Index of the master (0 or 1) that owns a one-hot grant vector.
   function automatic logic grant_owner(input logic [1:0] g);
      return g[1];
   endfunction

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Combinational 2-way tie-breaker: a lone request always wins. On a tie, master 0
// wins under fixed priority; otherwise the master that did not win last time wins.
`timescale 1ns/1ps
module mio_bus_arbiter_rr_arb2
   import mio_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       prio,
   output logic [1:0] win
);

   always_comb begin
      win = GRANT_NONE;
      case (req)
         2'b01:   win = GRANT_M0;
         2'b10:   win = GRANT_M1;
         2'b11:   win = (prio || last) ? GRANT_M0 : GRANT_M1;
         default: win = GRANT_NONE;
      endcase
   end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one synchronous memory port between master 0 (SCPU) and master 1. Each
// transaction is latched at grant and runs IDLE -> ACCESS -> DONE.
`timescale 1ns/1ps
module mio_bus_arbiter
   import mio_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int CPU_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic              s_en,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
   localparam logic             PRIO = (CPU_PRIORITY != 0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                last_q, last_d;
   logic [1:0]          grant_q, grant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
   logic [1:0]          win;

   mio_bus_arbiter_rr_arb2 u_arb (
      .req  ({m1_req, m0_req}),
      .last (last_q),
      .prio (PRIO),
      .win  (win)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         grant_q    <= GRANT_NONE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      grant_d    = grant_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;

      case (state_q)
         ST_IDLE: begin
            grant_d = GRANT_NONE;
            if (win != GRANT_NONE) begin
               // The command is frozen here; later master-side changes are ignored.
               state_d = ST_ACCESS;
               grant_d = win;
               last_d  = grant_owner(win);
               cnt_d   = '0;
               we_d    = grant_owner(win) ? m1_we    : m0_we;
               addr_d  = grant_owner(win) ? m1_addr  : m0_addr;
               wdata_d = grant_owner(win) ? m1_wdata : m0_wdata;
            end
         end

         ST_ACCESS: begin
            if (we_q) begin
               state_d = ST_DONE;
            end else if (cnt_q == LAT) begin
               state_d = ST_DONE;
               if (grant_owner(grant_q)) m1_rdata_d = s_rdata;
               else                      m0_rdata_d = s_rdata;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
            grant_d = GRANT_NONE;
         end

         default: begin
            state_d = ST_IDLE;
            grant_d = GRANT_NONE;
         end
      endcase
   end

   assign s_en     = (state_q == ST_ACCESS) && (cnt_q == '0);
   assign s_we     = s_en && we_q;
   assign s_addr   = addr_q;
   assign s_wdata  = wdata_q;
   assign grant    = grant_q;
   assign busy     = (state_q != ST_IDLE);
   assign m0_ready = (state_q == ST_DONE) && grant_q[0];
   assign m1_ready = (state_q == ST_DONE) && grant_q[1];
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Bench for mio_bus_arbiter: instance A (MEM_LAT=1, round-robin) and instance B
// (MEM_LAT=3, CPU priority), each with its own RAM model and reset.
`timescale 1ns/1ps
module tb_mio_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   logic        a_m0_req, a_m0_we, a_m0_ready, a_m1_req, a_m1_we, a_m1_ready;
   logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata, a_m1_addr, a_m1_wdata, a_m1_rdata;
   logic        a_s_en, a_s_we, a_busy;
   logic [31:0] a_s_addr, a_s_wdata, a_s_rdata;
   logic [1:0]  a_grant;

   logic        b_m0_req, b_m0_we, b_m0_ready, b_m1_req, b_m1_we, b_m1_ready;
   logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
   logic        b_s_en, b_s_we, b_busy;
   logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;
   logic [1:0]  b_grant;

   mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .CPU_PRIORITY(0)) dut_a (
      .clk(clk), .reset(rst_a),
      .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
      .m0_rdata(a_m0_rdata), .m0_ready(a_m0_ready),
      .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
      .m1_rdata(a_m1_rdata), .m1_ready(a_m1_ready),
      .s_en(a_s_en), .s_we(a_s_we), .s_addr(a_s_addr), .s_wdata(a_s_wdata),
      .s_rdata(a_s_rdata), .grant(a_grant), .busy(a_busy)
   );

   mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .CPU_PRIORITY(1)) dut_b (
      .clk(clk), .reset(rst_b),
      .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
      .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready),
      .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
      .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready),
      .s_en(b_s_en), .s_we(b_s_we), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
      .s_rdata(b_s_rdata), .grant(b_grant), .busy(b_busy)
   );

   function automatic logic [31:0] init_word(input int i);
      return (i == 16) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
   endfunction

   // RAM A: one-cycle registered read.
   logic [31:0] mem_a [256];
   logic [31:0] a_rd;
   always @(posedge clk) begin
      if (rst_a) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
      end else if (a_s_en) begin
         if (a_s_we) mem_a[a_s_addr[7:0]] <= a_s_wdata;
         else        a_rd <= mem_a[a_s_addr[7:0]];
      end
   end
   assign a_s_rdata = a_rd;

   // RAM B: read data valid three cycles after the strobe cycle.
   logic [31:0] mem_b [256];
   logic [31:0] b_p1, b_p2, b_p3;
   always @(posedge clk) begin
      if (rst_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
      end else if (b_s_en) begin
         if (b_s_we) mem_b[b_s_addr[7:0]] <= b_s_wdata;
         else        b_p1 <= mem_b[b_s_addr[7:0]];
      end
      b_p2 <= b_p1;
      b_p3 <= b_p2;
   end
   assign b_s_rdata = b_p3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  who;
      int          lat;
      logic [31:0] rdata;
      bit          is_rd;
   } exp_t;
   exp_t sb[$];

   logic [31:0] ref_a [256];

   int          obs_cyc, obs_en, obs_we;
   logic [1:0]  obs_who;

   task automatic reinit_ref_a();
      for (int i = 0; i < 256; i++) ref_a[i] = init_word(i);
   endtask

   task automatic push_exp(input logic [1:0] who, input int lat, input logic [31:0] rd, input bit is_rd);
      exp_t e;
      e.who = who; e.lat = lat; e.rdata = rd; e.is_rd = is_rd;
      sb.push_back(e);
   endtask

   // Advances on negedges until a ready pulse (or the budget runs out, leaving obs_cyc=-1).
   task automatic wait_ready(input bit use_b, input int budget);
      logic r0, r1;
      obs_cyc = -1; obs_who = 2'b00; obs_en = 0; obs_we = 0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (use_b ? b_s_en : a_s_en) begin
            obs_en++;
            if (use_b ? b_s_we : a_s_we) obs_we++;
         end
         r0 = use_b ? b_m0_ready : a_m0_ready;
         r1 = use_b ? b_m1_ready : a_m1_ready;
         if (r0 || r1) begin
            obs_who = {r1, r0};
            obs_cyc = k;
            return;
         end
      end
   endtask

   task automatic pulse_reset_a();
      @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      reinit_ref_a();
   endtask

   task automatic test_reset();
      #3;
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      checks++;
      if ({a_m0_ready, a_m1_ready, a_s_en, a_s_we, a_grant, a_busy, a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_async_a: outputs not all zero (grant=%b busy=%b s_en=%b)", a_grant, a_busy, a_s_en);
      end
      checks++;
      if ({b_m0_ready, b_m1_ready, b_s_en, b_s_we, b_grant, b_busy, b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_async_b: outputs not all zero (grant=%b busy=%b s_en=%b)", b_grant, b_busy, b_s_en);
      end
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
      reinit_ref_a();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (a_grant !== 2'b00 || a_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: grant=%b busy=%b, expected grant=00 busy=0", a_grant, a_busy);
      end
   endtask

   task automatic test_single_read();
      exp_t e;
      a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h10;
      push_exp(2'b01, 3, ref_a[16], 1'b1);
      wait_ready(1'b0, 12);
      a_m0_req = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs_who !== e.who) begin
         errors++; $display("FAIL rd_owner: ready={m1,m0}=%b, expected %b", obs_who, e.who);
      end
      checks++;
      if (obs_cyc != e.lat) begin
         errors++; $display("FAIL rd_latency: %0d cycles, expected %0d", obs_cyc, e.lat);
      end
      checks++;
      if (a_m0_rdata !== e.rdata) begin
         errors++; $display("FAIL rd_data: m0_rdata=%h, expected %h", a_m0_rdata, e.rdata);
      end
      checks++;
      if (obs_en != 1 || obs_we != 0) begin
         errors++; $display("FAIL rd_strobe: s_en cycles=%0d s_we cycles=%0d, expected 1 and 0", obs_en, obs_we);
      end
      @(negedge clk);
      checks++;
      if (a_m0_ready !== 1'b0 || a_busy !== 1'b0 || a_grant !== 2'b00) begin
         errors++; $display("FAIL rd_after: ready=%b busy=%b grant=%b, expected 0 0 00", a_m0_ready, a_busy, a_grant);
      end
   endtask

   task automatic test_write();
      exp_t e;
      a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'h20; a_m1_wdata = 32'h12345678;
      push_exp(2'b10, 2, 32'h0, 1'b0);
      ref_a[32] = 32'h12345678;
      wait_ready(1'b0, 12);
      a_m1_req = 1'b0; a_m1_we = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs_who !== e.who || obs_cyc != e.lat) begin
         errors++; $display("FAIL wr_ready: owner=%b cycles=%0d, expected %b %0d", obs_who, obs_cyc, e.who, e.lat);
      end
      checks++;
      if (obs_en != 1 || obs_we != 1) begin
         errors++; $display("FAIL wr_strobe: s_en cycles=%0d s_we cycles=%0d, expected 1 and 1", obs_en, obs_we);
      end
      checks++;
      if (a_m0_rdata !== 32'hDEADBEEF || a_m1_rdata !== 32'h0) begin
         errors++; $display("FAIL wr_rdata_hold: m0_rdata=%h m1_rdata=%h, expected deadbeef 0", a_m0_rdata, a_m1_rdata);
      end
      @(negedge clk);
      a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h20;
      push_exp(2'b01, 3, ref_a[32], 1'b1);
      wait_ready(1'b0, 12);
      a_m0_req = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs_who !== e.who || obs_cyc != e.lat || a_m0_rdata !== e.rdata) begin
         errors++;
         $display("FAIL wr_readback: owner=%b cycles=%0d data=%h, expected %b %0d %h", obs_who, obs_cyc, a_m0_rdata, e.who, e.lat, e.rdata);
      end
      checks++;
      if (a_m1_rdata !== 32'h0) begin
         errors++; $display("FAIL wr_nonowner_hold: m1_rdata=%h, expected 0", a_m1_rdata);
      end
   endtask

   task automatic test_rr_tie();
      exp_t e;
      pulse_reset_a();
      a_m0_we = 1'b0; a_m0_addr = 32'h05;
      a_m1_we = 1'b0; a_m1_addr = 32'h06;
      for (int t = 0; t < 4; t++)
         push_exp((t % 2 == 0) ? 2'b01 : 2'b10, (t == 0) ? 3 : 4, (t % 2 == 0) ? ref_a[5] : ref_a[6], 1'b1);
      a_m0_req = 1'b1; a_m1_req = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_ready(1'b0, 12);
         if (t == 3) begin a_m0_req = 1'b0; a_m1_req = 1'b0; end
         e = sb.pop_front();
         checks++;
         if (obs_who !== e.who || obs_cyc != e.lat) begin
            errors++; $display("FAIL rr_grant_%0d: owner=%b cycles=%0d, expected %b %0d", t, obs_who, obs_cyc, e.who, e.lat);
         end
         checks++;
         if ((e.who[1] ? a_m1_rdata : a_m0_rdata) !== e.rdata) begin
            errors++; $display("FAIL rr_data_%0d: rdata=%h, expected %h", t, e.who[1] ? a_m1_rdata : a_m0_rdata, e.rdata);
         end
      end
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || a_grant !== 2'b00) begin
         errors++; $display("FAIL rr_idle: busy=%b grant=%b, expected 0 00", a_busy, a_grant);
      end
   endtask

   task automatic test_cmd_stability();
      exp_t e;
      int extra;
      a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h10;
      push_exp(2'b01, 2, ref_a[16], 1'b1);
      @(negedge clk);
      checks++;
      if (a_s_en !== 1'b1 || a_s_addr !== 32'h10) begin
         errors++; $display("FAIL stab_strobe: s_en=%b s_addr=%h, expected 1 10", a_s_en, a_s_addr);
      end
      a_m0_addr = 32'h30; a_m0_req = 1'b0;
      wait_ready(1'b0, 12);
      e = sb.pop_front();
      checks++;
      if (obs_who !== e.who || obs_cyc != e.lat || a_s_addr !== 32'h10) begin
         errors++; $display("FAIL stab_ready: owner=%b cycles=%0d s_addr=%h, expected %b %0d 10", obs_who, obs_cyc, a_s_addr, e.who, e.lat);
      end
      checks++;
      if (a_m0_rdata !== e.rdata) begin
         errors++; $display("FAIL stab_data: m0_rdata=%h, expected %h", a_m0_rdata, e.rdata);
      end
      extra = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (a_m0_ready || a_m1_ready || a_busy) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++; $display("FAIL stab_single: %0d busy/ready cycles after completion, expected 0", extra);
      end
   endtask

   task automatic test_prio_tie();
      exp_t e;
      b_m0_we = 1'b0; b_m0_addr = 32'h07;
      b_m1_we = 1'b0; b_m1_addr = 32'h08;
      for (int t = 0; t < 3; t++) push_exp(2'b01, (t == 0) ? 5 : 6, init_word(7), 1'b1);
      b_m0_req = 1'b1; b_m1_req = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_ready(1'b1, 16);
         if (t == 2) begin b_m0_req = 1'b0; b_m1_req = 1'b0; end
         e = sb.pop_front();
         checks++;
         if (obs_who !== e.who || obs_cyc != e.lat || b_m0_rdata !== e.rdata) begin
            errors++;
            $display("FAIL prio_grant_%0d: owner=%b cycles=%0d data=%h, expected %b %0d %h", t, obs_who, obs_cyc, b_m0_rdata, e.who, e.lat, e.rdata);
         end
      end
      checks++;
      if (b_m1_rdata !== 32'h0) begin
         errors++; $display("FAIL prio_m1_untouched: m1_rdata=%h, expected 0", b_m1_rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      exp_t e;
      int stray;
      @(negedge clk);
      b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h09;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      b_m0_req = 1'b0;
      #1;
      checks++;
      if (b_busy !== 1'b0 || b_grant !== 2'b00 || b_s_en !== 1'b0 || b_m0_ready !== 1'b0 || b_m0_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midrst_async: busy=%b grant=%b s_en=%b ready=%b rdata=%h, expected all 0", b_busy, b_grant, b_s_en, b_m0_ready, b_m0_rdata);
      end
      @(negedge clk);
      rst_b = 1'b0;
      stray = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (b_m0_ready || b_m1_ready || b_busy) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++; $display("FAIL midrst_no_ready: %0d busy/ready cycles after reset, expected 0", stray);
      end
      b_m0_req = 1'b1; b_m0_addr = 32'h0A;
      push_exp(2'b01, 5, init_word(10), 1'b1);
      wait_ready(1'b1, 16);
      b_m0_req = 1'b0;
      e = sb.pop_front();
      checks++;
      if (obs_who !== e.who || obs_cyc != e.lat || b_m0_rdata !== e.rdata) begin
         errors++;
         $display("FAIL midrst_recover: owner=%b cycles=%0d data=%h, expected %b %0d %h", obs_who, obs_cyc, b_m0_rdata, e.who, e.lat, e.rdata);
      end
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = '0; a_m0_wdata = '0;
      a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = '0; a_m1_wdata = '0;
      b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
      b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
      test_reset();
      test_single_read();
      test_write();
      test_rr_tie();
      test_cmd_stability();
      test_prio_tie();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
